key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Multi-key input conditioner, the input-side counterpart of the board's LED output logic. It synchronises raw push-button inputs and debounces each key independently. Per key, it produces a clean level plus single-cycle press, release and auto-repeat pulses. Downstream logic uses the pulses as count-enable and step events, for example to advance LED patterns.

Parameters:
N_KEYS, 4, number of independent keys
ACTIVE_LOW, 1, 1 = key_in reads 0 when pressed; 0 = reads 1 when pressed
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be >= 1
HOLD_CYCLES, 25000000, cycles in debounced-pressed state before first repeat pulse; 0 disables repeat
REPEAT_CYCLES, 5000000, cycles between subsequent repeat pulses; must be >= 1 when HOLD_CYCLES > 0

Ports:
clk  input  1  system clock; the single clock domain
rst  input  1  synchronous, active-high reset
key_in  input  N_KEYS  raw asynchronous key levels, polarity per ACTIVE_LOW
key_state  output  N_KEYS  debounced level, 1 = pressed
key_press  output  N_KEYS  1-cycle pulse on accepted press
key_release  output  N_KEYS  1-cycle pulse on accepted release
key_repeat  output  N_KEYS  1-cycle pulse on hold and on each auto-repeat
any_press  output  1  OR of key_press, registered in the same cycle as key_press

Behaviour:
- Single clock domain, clk. rst is sampled on the rising edge; there is no asynchronous path.
- Reset:
  - All outputs are 0.
  - Synchroniser flops are loaded with the inactive level (all 1 if ACTIVE_LOW, else all 0), so no spurious press occurs after reset.
  - All FSMs go to IDLE and all counters to 0.
- Reset asserted mid-operation (in any state) has the same effect within the same edge. Pulses in flight are dropped.
- Synchroniser: two flops per key. The normalised signal p = synchronised level XOR ACTIVE_LOW (p = 1 means pressed).
- Per-key FSM: keys are fully independent, with a debounce counter dcnt and a hold counter hcnt per key.
  - IDLE: if p, go to PRESS_DB with dcnt = 0.
  - PRESS_DB:
    - If !p, return to IDLE (bounce rejected); no pulse.
    - Else if dcnt == DEB_CYCLES-1, go to PRESSED: key_state <= 1, key_press <= 1, hcnt <= 0, repeat phase <= HOLD.
    - Else dcnt++.
  - PRESSED:
    - If !p, go to RELEASE_DB with dcnt = 0; hcnt is frozen.
    - Else, when HOLD_CYCLES > 0, hcnt++. When hcnt reaches the phase limit (HOLD_CYCLES-1 in HOLD phase, REPEAT_CYCLES-1 in REPEAT phase): key_repeat <= 1, hcnt <= 0, phase <= REPEAT.
  - RELEASE_DB:
    - If p, return to PRESSED with hcnt and phase preserved; no pulse.
    - Else if dcnt == DEB_CYCLES-1, go to IDLE: key_state <= 0, key_release <= 1.
    - Else dcnt++.
    - No repeat pulses are issued in RELEASE_DB.
- Latency: let edge k be the first edge that samples key_in active, with key_in held stable afterwards. Then key_state and key_press rise on edge k+DEB_CYCLES+2, and key_press falls on the next edge. Release latency is symmetric.
- Repeat timing: let edge P be the edge on which key_press rises. key_repeat pulses at P+HOLD_CYCLES, then every REPEAT_CYCLES edges while held and not in RELEASE_DB.
- Pulse width: every pulse output is exactly 1 cycle. key_press and key_repeat are never high in the same cycle for the same key.
- Counter widths: dcnt is clog2(DEB_CYCLES+1) bits; hcnt is clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1) bits. Counters never wrap, because each is reset at its limit.
- Simultaneous events: multiple keys may pulse in the same cycle. any_press is the OR of their key_press bits.

Test Plan:
- Reset values: assert rst for 3 cycles with key_in = 4'hF, ACTIVE_LOW = 1 -> all outputs 0. With rst still high, drive key_in = 0 -> outputs remain 0.
- Clean press (DEB_CYCLES=4, HOLD_CYCLES=0): key_in[0] driven low before edge k and held -> key_state[0] and key_press[0] rise at edge k+6; key_press[0] is high for exactly 1 cycle; any_press = 1 in that same cycle.
- Bounce rejection (DEB_CYCLES=4): key_in[1] toggled low 3 cycles / high 1 cycle, repeated 5 times -> no key_press[1]. Then hold low -> press at first sampled-low edge + 6.
- Hold/repeat (DEB=4, HOLD=10, REPEAT=5): press key 2 with press at edge P, hold 30 cycles -> key_repeat[2] at P+10, P+15, P+20, P+25, P+30. Release -> key_release[2] at 6 edges after first high sample; no repeats after release begins.
- Release glitch (DEB=4): while key 3 is pressed, a 2-cycle high glitch -> no key_release[3]; key_state[3] stays 1; repeat schedule resumes with hcnt preserved.
- Concurrent keys plus reset mid-debounce: keys 0 and 1 pressed on the same edge -> both key_press bits high in the same cycle, any_press = 1. Then press key 2, assert rst during PRESS_DB, release rst with key held -> key_press[2] only at the first post-reset sampled edge + 6.

Source files
------------

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronised, per-key debounced push-button conditioner
// Emits a clean level plus single-cycle press, release and auto-repeat pulses.
module key_debounce #(
  parameter int N_KEYS        = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              any_press
);

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW   = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [N_KEYS-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_PRESSED,
    S_RELEASE_DB
  } state_t;

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] p;

  state_t          state_q [N_KEYS];
  state_t          state_d [N_KEYS];
  logic [DW-1:0]   dcnt_q  [N_KEYS];
  logic [DW-1:0]   dcnt_d  [N_KEYS];
  logic [HW-1:0]   hcnt_q  [N_KEYS];
  logic [HW-1:0]   hcnt_d  [N_KEYS];

  // rep_phase: 0 = waiting out the initial hold, 1 = in the repeat cadence
  logic [N_KEYS-1:0] rep_phase_q,   rep_phase_d;
  logic [N_KEYS-1:0] key_state_q,   key_state_d;
  logic [N_KEYS-1:0] key_press_q,   key_press_d;
  logic [N_KEYS-1:0] key_release_q, key_release_d;
  logic [N_KEYS-1:0] key_repeat_q,  key_repeat_d;
  logic              any_press_q,   any_press_d;

  assign p = sync2_q ^ IDLE_LVL;

  always_comb begin
    key_state_d   = key_state_q;
    rep_phase_d   = rep_phase_q;
    key_press_d   = '0;
    key_release_d = '0;
    key_repeat_d  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      hcnt_d[i]  = hcnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (p[i]) begin
            state_d[i] = S_PRESS_DB;
            dcnt_d[i]  = '0;
          end
        end
        S_PRESS_DB: begin
          if (!p[i]) begin
            state_d[i] = S_IDLE;
          end else if (dcnt_q[i] == DEB_LAST) begin
            state_d[i]     = S_PRESSED;
            key_state_d[i] = 1'b1;
            key_press_d[i] = 1'b1;
            hcnt_d[i]      = '0;
            rep_phase_d[i] = 1'b0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!p[i]) begin
            state_d[i] = S_RELEASE_DB;
            dcnt_d[i]  = '0;
          end else if (HOLD_CYCLES > 0) begin
            if (hcnt_q[i] == (rep_phase_q[i] ? REP_LAST : HOLD_LAST)) begin
              key_repeat_d[i] = 1'b1;
              hcnt_d[i]       = '0;
              rep_phase_d[i]  = 1'b1;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 1'b1;
            end
          end
        end
        S_RELEASE_DB: begin
          // hcnt and phase are left untouched so a rejected glitch resumes the schedule
          if (p[i]) begin
            state_d[i] = S_PRESSED;
          end else if (dcnt_q[i] == DEB_LAST) begin
            state_d[i]       = S_IDLE;
            key_state_d[i]   = 1'b0;
            key_release_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
    any_press_d = |key_press_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= IDLE_LVL;
      sync2_q       <= IDLE_LVL;
      rep_phase_q   <= '0;
      key_state_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      key_repeat_q  <= '0;
      any_press_q   <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= S_IDLE;
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q       <= key_in;
      sync2_q       <= sync1_q;
      rep_phase_q   <= rep_phase_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_repeat_q  <= key_repeat_d;
      any_press_q   <= any_press_d;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_repeat  = key_repeat_q;
  assign any_press   = any_press_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int DEB = 4;
  localparam int HLD = 10;
  localparam int REP = 5;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;

  logic          clk;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_repeat;
  logic          any_press;

  key_debounce #(
    .N_KEYS       (NK),
    .ACTIVE_LOW   (1),
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .any_press  (any_press)
  );

  typedef struct {
    int at;
    int key;
    int kind;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  edge_n  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic string kind_name(input int t);
    case (t)
      K_PRESS:   return "press";
      K_RELEASE: return "release";
      default:   return "repeat";
    endcase
  endfunction

  task automatic push(input int at, input int key, input int kind);
    ev_t e;
    e.at   = at;
    e.key  = key;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Monitor: every pulse bit is compared against the scoreboard on every cycle
  logic m_obs, m_exp, m_any;
  always @(negedge clk) begin
    m_any = 1'b0;
    foreach (sb[j]) if (sb[j].at == edge_n && sb[j].kind == K_PRESS) m_any = 1'b1;
    check($sformatf("e%0d_any_press", edge_n), any_press, m_any);
    for (int i = 0; i < NK; i++) begin
      for (int t = 0; t < 3; t++) begin
        m_obs = (t == K_PRESS) ? key_press[i] : (t == K_RELEASE) ? key_release[i] : key_repeat[i];
        m_exp = 1'b0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
          if (sb[j].at == edge_n && sb[j].key == i && sb[j].kind == t) begin
            m_exp = 1'b1;
            sb.delete(j);
          end
        end
        check($sformatf("e%0d_k%0d_%s", edge_n, i, kind_name(t)), m_obs, m_exp);
      end
    end
  end

  // Press key i, hold it for n sampled cycles, release; expects press, repeats and release
  task automatic hold_key(input int i, input int n);
    int k, pe, kr;
    @(negedge clk);
    key_in[i] = 1'b0;
    k  = edge_n + 1;
    pe = k + DEB + 2;
    kr = k + n;
    push(pe, i, K_PRESS);
    for (int t = pe + HLD; t <= kr + 1; t += REP) push(t, i, K_REPEAT);
    push(kr + DEB + 2, i, K_RELEASE);
    wait_edge(pe - 1);
    check($sformatf("k%0d_state_before_press", i), key_state[i], 1'b0);
    wait_edge(pe);
    check($sformatf("k%0d_state_pressed", i), key_state[i], 1'b1);
    wait_edge(kr - 1);
    key_in[i] = 1'b1;
    wait_edge(kr + DEB + 1);
    check($sformatf("k%0d_state_before_release", i), key_state[i], 1'b1);
    wait_edge(kr + DEB + 2);
    check($sformatf("k%0d_state_released", i), key_state[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pe;
    rst    = 1'b1;
    key_in = '1;
    repeat (3) @(negedge clk);
    check("rst_state", key_state, 0);
    check("rst_pulses", {key_press, key_release, key_repeat, any_press}, 0);
    key_in = '0;
    repeat (3) @(negedge clk);
    check("rst_keys_low_state", key_state, 0);
    check("rst_keys_low_pulses", {key_press, key_release, key_repeat, any_press}, 0);
    key_in = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_state", key_state, 0);

    // clean press on key 0
    hold_key(0, 12);
    repeat (8) @(negedge clk);

    // bouncing key 1: three low samples, one high, five times
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      key_in[1] = 1'b0;
      repeat (3) @(negedge clk);
      key_in[1] = 1'b1;
    end
    check("bounce_k1_state", key_state[1], 1'b0);
    hold_key(1, 12);
    repeat (8) @(negedge clk);

    // long hold on key 2: repeats at P+10..P+30
    hold_key(2, 39);
    repeat (8) @(negedge clk);

    // release glitch on key 3: two high samples six cycles after the press
    @(negedge clk);
    key_in[3] = 1'b0;
    k  = edge_n + 1;
    pe = k + DEB + 2;
    push(pe, 3, K_PRESS);
    push(pe + 13, 3, K_REPEAT);
    push(pe + 18, 3, K_REPEAT);
    push(pe + 26, 3, K_RELEASE);
    wait_edge(k + 11);
    key_in[3] = 1'b1;
    wait_edge(k + 13);
    key_in[3] = 1'b0;
    wait_edge(pe + 9);
    check("glitch_k3_state_held", key_state[3], 1'b1);
    wait_edge(pe + 19);
    key_in[3] = 1'b1;
    wait_edge(pe + 25);
    check("glitch_k3_state_before_release", key_state[3], 1'b1);
    wait_edge(pe + 26);
    check("glitch_k3_state_released", key_state[3], 1'b0);
    repeat (8) @(negedge clk);

    // keys 0 and 1 pressed on the same edge
    fork
      hold_key(0, 12);
      hold_key(1, 12);
    join
    repeat (8) @(negedge clk);

    // reset while key 2 is in press debounce
    @(negedge clk);
    key_in[2] = 1'b0;
    k = edge_n + 1;
    wait_edge(k + 3);
    rst = 1'b1;
    wait_edge(k + 4);
    check("midrst_state", key_state, 0);
    wait_edge(k + 5);
    rst = 1'b0;
    pe = k + 6 + DEB + 2;
    push(pe, 2, K_PRESS);
    push(pe + 2 + DEB + 2, 2, K_RELEASE);
    wait_edge(pe - 1);
    check("midrst_k2_state_before_press", key_state[2], 1'b0);
    wait_edge(pe);
    check("midrst_k2_state_pressed", key_state[2], 1'b1);
    wait_edge(pe + 1);
    key_in[2] = 1'b1;
    wait_edge(pe + 2 + DEB + 2);
    check("midrst_k2_state_released", key_state[2], 1'b0);

    repeat (15) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
